// File: rtl/iob_wishbone2iob.sv
// rtl/iob_wishbone2iob.sv - Wishbone slave to IOb master bridge with wait timeout
module iob_wishbone2iob #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                wb_rst_i,
  // Wishbone slave side
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic                wb_ack_o,
  output logic                wb_error_o,
  output logic [DATA_W-1:0]   wb_data_o,
  // IOb master side
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  localparam int STRB_W = DATA_W / 8;
  // The counter only needs to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that decides the error.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               start;
  logic               accept;

  assign start  = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign accept = (state_q == S_WAIT) && ready_i;

  // State and wait counter registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one IOb request at a time, ready beats the timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (ready_i) begin
          // A master that dropped cyc no longer wants the response
          state_d = wb_cyc_i ? S_ACK : S_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture in IDLE and response capture on an accepted ready
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else if (wb_rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        addr_q  <= wb_addr_i;
        wdata_q <= wb_data_i;
        wstrb_q <= wb_we_i ? wb_select_i : '0;
      end
      if (accept) rdata_q <= rdata_i;
    end
  end

  assign valid_o    = (state_q == S_REQ);
  assign address_o  = addr_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;
  assign wb_data_o  = rdata_q;
  assign wb_ack_o   = (state_q == S_ACK) && wb_cyc_i;
  assign wb_error_o = (state_q == S_ERR) && wb_cyc_i;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// tb/tb_iob_wishbone2iob.sv - self-checking bench for iob_wishbone2iob
module tb_iob_wishbone2iob;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          arst_n_i;
  logic          wb_rst_i;
  logic [AW-1:0] wb_addr_i;
  logic [3:0]    wb_select_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [DW-1:0] wb_data_i;
  logic          wb_ack_o;
  logic          wb_error_o;
  logic [DW-1:0] wb_data_o;
  logic          valid_o;
  logic [AW-1:0] address_o;
  logic [DW-1:0] wdata_o;
  logic [3:0]    wstrb_o;
  logic [DW-1:0] rdata_i;
  logic          ready_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_rdata;

  iob_wishbone2iob #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .wb_rst_i(wb_rst_i),
    .wb_addr_i(wb_addr_i), .wb_select_i(wb_select_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_data_i(wb_data_i),
    .wb_ack_o(wb_ack_o), .wb_error_o(wb_error_o), .wb_data_o(wb_data_o),
    .valid_o(valid_o), .address_o(address_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .rdata_i(rdata_i), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  // One transfer, starting right after a rising edge. The master's first
  // ready arrives in WAIT cycle k; it is honoured only if k <= TO, otherwise
  // the error fires after TO empty WAIT cycles and the ready is dropped.
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                          input logic we, input int k, input logic [31:0] rd);
    int end_c;
    bit ok;
    logic [3:0] exp_strb;
    logic [2:0] obs, expv;
    ok       = (k <= TO);
    end_c    = ok ? k + 2 : TO + 2;
    exp_strb = we ? sel : 4'h0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_addr_i = a; wb_data_i = d;
    wb_select_i = sel; wb_we_i = we; ready_i = 1'b0;
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0; wb_addr_i = $urandom; wb_data_i = $urandom; wb_select_i = 4'($urandom);
    for (int j = 1; j <= end_c + 1; j++) begin
      ready_i = (j == k + 1);
      rdata_i = ready_i ? rd : $urandom;
      @(negedge clk_i);
      if (ok && j == k + 2) exp_rdata = rd;
      expv = {j == 1, ok && j == end_c, !ok && j == end_c};
      obs  = {valid_o, wb_ack_o, wb_error_o};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL xfer_handshake a=%h k=%0d cycle %0d: valid/ack/err got %b expected %b", a, k, j, obs, expv);
      end
      checks++;
      if ({address_o, wdata_o, wstrb_o} !== {a, d, exp_strb}) begin
        errors++;
        $display("FAIL xfer_request cycle %0d: got %h/%h/%h expected %h/%h/%h", j, address_o, wdata_o, wstrb_o, a, d, exp_strb);
      end
      checks++;
      if (wb_data_o !== exp_rdata) begin
        errors++;
        $display("FAIL xfer_rdata cycle %0d: got %h expected %h", j, wb_data_o, exp_rdata);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0;
    wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset;
    arst_n_i = 1'b0; wb_rst_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_select_i = 4'hF;
    wb_addr_i = $urandom; wb_data_i = $urandom; rdata_i = $urandom; ready_i = 1'b1;
    exp_rdata = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({valid_o, wb_ack_o, wb_error_o, address_o, wdata_o, wstrb_o, wb_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v%b a%b e%b %h %h %h %h expected all zero",
               valid_o, wb_ack_o, wb_error_o, address_o, wdata_o, wstrb_o, wb_data_o);
    end
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    // first capture happens on the edge right after release
    run_xfer(32'h55, 32'hA5A5_0001, 4'h1, 1'b0, 1, 32'hCAFE_0001);
  endtask

  task automatic test_read;
    run_xfer(32'h100, $urandom, 4'hF, 1'b0, 1, 32'hDEAD_BEEF);
  endtask

  task automatic test_write;
    // ready five cycles after stb is sampled lands on the last WAIT cycle
    run_xfer(32'h200, 32'h1234_5678, 4'h3, 1'b1, TO, $urandom);
  endtask

  task automatic test_timeout;
    run_xfer(32'h400, $urandom, 4'hF, 1'b0, TO + 2, $urandom);
    run_xfer(32'h404, $urandom, 4'hF, 1'b0, TO + 1, $urandom);
    run_xfer(32'h408, $urandom, 4'hF, 1'b0, 2, $urandom);
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    rd = $urandom;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h300;
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j >= 2) wb_cyc_i = 1'b0;
      ready_i = (j == 5);
      rdata_i = ready_i ? rd : $urandom;
      @(negedge clk_i);
      checks++;
      if ({valid_o, wb_ack_o, wb_error_o} !== {j == 1, 2'b00}) begin
        errors++;
        $display("FAIL abort_handshake cycle %0d: got %b%b%b", j, valid_o, wb_ack_o, wb_error_o);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0;
    exp_rdata = rd;
    checks++;
    if (wb_data_o !== rd) begin
      errors++;
      $display("FAIL abort_rdata: got %h expected %h", wb_data_o, rd);
    end
    run_xfer(32'h304, $urandom, 4'hF, 1'b0, 1, $urandom);
  endtask

  task automatic test_reset_midop;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_select_i = 4'hF;
    wb_addr_i = 32'h8000_0010; wb_data_i = 32'hFFFF_0000; ready_i = 1'b0;
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i); #2;
    arst_n_i = 1'b0;
    #1;
    exp_rdata = '0;
    checks++;
    if ({valid_o, wb_ack_o, wb_error_o, address_o, wdata_o, wstrb_o, wb_data_o} !== '0) begin
      errors++;
      $display("FAIL arst_midop: outputs got %h %h %h %h flags %b%b%b expected zero",
               address_o, wdata_o, wstrb_o, wb_data_o, valid_o, wb_ack_o, wb_error_o);
    end
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ready_i = 1'b1; rdata_i = $urandom;
      @(negedge clk_i);
      checks++;
      if ({valid_o, wb_ack_o, wb_error_o, wb_data_o} !== '0) begin
        errors++;
        $display("FAIL arst_after: got %b%b%b data %h", valid_o, wb_ack_o, wb_error_o, wb_data_o);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0;
    // synchronous reset while the request is on the bus
    wb_stb_i = 1'b1; wb_addr_i = 32'h0000_0ABC;
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0; wb_rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1 || address_o !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL wbrst_before: valid %b addr %h expected 1 00000abc", valid_o, address_o);
    end
    @(posedge clk_i); #1;
    wb_rst_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ready_i = 1'b1; rdata_i = $urandom;
      @(negedge clk_i);
      checks++;
      if ({valid_o, wb_ack_o, wb_error_o, address_o, wdata_o, wstrb_o, wb_data_o} !== '0) begin
        errors++;
        $display("FAIL wbrst_after cycle %0d: flags %b%b%b addr %h data %h", j, valid_o, wb_ack_o, wb_error_o, address_o, wb_data_o);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [31:0] rds [4];
    int vcyc [4];
    int acyc [4];
    int vc, ac, idx;
    bit acked;
    vc = 0; ac = 0; idx = 0;
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'(i * 4);
      rds[i] = $urandom;
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_addr_i = addrs[0]; rdata_i = rds[0]; ready_i = 1'b1;
    for (int c = 0; c < 40 && ac < 4; c++) begin
      @(negedge clk_i);
      acked = wb_ack_o;
      if (valid_o) begin
        if (vc < 4) begin
          vcyc[vc] = c;
          checks++;
          if (address_o !== addrs[vc]) begin
            errors++;
            $display("FAIL b2b_addr %0d: got %h expected %h", vc, address_o, addrs[vc]);
          end
        end
        vc++;
      end
      if (acked) begin
        if (ac < 4) begin
          acyc[ac] = c;
          checks++;
          if (wb_data_o !== rds[ac]) begin
            errors++;
            $display("FAIL b2b_data %0d: got %h expected %h", ac, wb_data_o, rds[ac]);
          end
        end
        ac++;
      end
      @(posedge clk_i); #1;
      if (acked) begin
        idx++;
        if (idx < 4) begin
          wb_addr_i = addrs[idx]; rdata_i = rds[idx];
        end else begin
          wb_stb_i = 1'b0; wb_cyc_i = 1'b0; ready_i = 1'b0;
        end
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; ready_i = 1'b0;
    exp_rdata = rds[3];
    checks++;
    if (vc !== 4 || ac !== 4) begin
      errors++;
      $display("FAIL b2b_count: valid pulses %0d acks %0d expected 4 4", vc, ac);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acyc[i] - acyc[i-1] != 4 || vcyc[i] - vcyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_spacing %0d: ack gap %0d valid gap %0d expected 4", i, acyc[i] - acyc[i-1], vcyc[i] - vcyc[i-1]);
        end
      end
    end
    @(negedge clk_i);
    checks++;
    if ({valid_o, wb_ack_o, wb_error_o} !== 3'b000 || wb_data_o !== exp_rdata) begin
      errors++;
      $display("FAIL b2b_idle: flags %b%b%b data %h expected 000 %h", valid_o, wb_ack_o, wb_error_o, wb_data_o, exp_rdata);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_xfer($urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(TO + 2, 1), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iob_wishbone2iob.md
IOB_WISHBONE2IOB -- requirements
Module: iob_wishbone2iob

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width on both ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width; DATA_W/8 byte lanes.
REQ-003 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before error; 0 disables timeout.
REQ-004 SHALL have ports: clk_i in 1 clock; arst_n_i in 1 async active-low reset; wb_rst_i in 1 sync active-high Wishbone reset.
REQ-005 SHALL have Wishbone slave inputs: wb_addr_i ADDR_W; wb_select_i DATA_W/8; wb_we_i 1; wb_cyc_i 1; wb_stb_i 1; wb_data_i DATA_W.
REQ-006 SHALL have Wishbone slave outputs: wb_ack_o 1; wb_error_o 1; wb_data_o DATA_W read data.
REQ-007 SHALL have IOb master outputs: valid_o 1; address_o ADDR_W; wdata_o DATA_W; wstrb_o DATA_W/8.
REQ-008 SHALL have IOb master inputs: rdata_i DATA_W; ready_i 1.
REQ-009 One clock (clk_i, rising edge); reset asynchronous and active-low (arst_n_i); these are fixed.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, ACK, ERR, encoded in a registered state variable.
REQ-011 IDLE: when wb_cyc_i&wb_stb_i, SHALL register wb_addr_i, wb_data_i, wstrb = wb_we_i ? wb_select_i : 0, and go to REQ; else stay.
REQ-012 REQ: valid_o SHALL be 1 for exactly this one cycle; address_o/wdata_o/wstrb_o SHALL drive registered values; next state WAIT.
REQ-013 address_o, wdata_o, wstrb_o SHALL hold registered values in all states (stable until next IDLE capture).
REQ-014 WAIT: on ready_i=1, SHALL register rdata_i into wb_data_o and go to ACK (if wb_cyc_i=1) or IDLE (if wb_cyc_i=0, aborted cycle, no ack).
REQ-015 ready_i SHALL be ignored in IDLE, REQ, ACK, ERR.
REQ-016 WAIT: timeout counter SHALL clear on entry and increment each WAIT cycle without ready_i; when count reaches TIMEOUT (TIMEOUT>0) with no ready_i, go to ERR.
REQ-017 ready_i in the same cycle count reaches TIMEOUT SHALL win: go to ACK, no error.
REQ-018 ACK: wb_ack_o=1 exactly one cycle, wb_error_o=0; next state IDLE.
REQ-019 ERR: wb_error_o=1 exactly one cycle, wb_ack_o=0; wb_data_o unchanged; next state IDLE.
REQ-020 wb_ack_o and wb_error_o SHALL never be 1 simultaneously, and SHALL be 0 when wb_cyc_i=0.
REQ-021 A ready_i arriving after a timeout (in IDLE) SHALL be discarded.
REQ-022 wb_data_o SHALL update only on accepted ready_i; write transfers (wstrb≠0) SHALL still capture rdata_i.
REQ-023 Latency: stb sampled in IDLE at edge N -> valid_o in cycle N+1 -> earliest ready_i cycle N+2 -> wb_ack_o cycle N+3.
REQ-024 Back-to-back: master holding stb with new address after ack SHALL get it captured in the IDLE cycle following ACK.
REQ-025 Only one IOb transaction SHALL be outstanding at any time.

Reset
REQ-026 arst_n_i=0 SHALL asynchronously force state IDLE, counter 0, valid_o=0, wb_ack_o=0, wb_error_o=0, address_o/wdata_o/wstrb_o/wb_data_o=0.
REQ-027 wb_rst_i=1 at a rising edge SHALL produce the same state/values synchronously, overriding all other inputs, including mid-transaction (no ack/error issued for that transfer).
REQ-028 Deassertion of arst_n_i SHALL take effect at the next clk_i edge; first capture possible at that edge.

Verification
REQ-029 Read: stb, we=0, addr=0x100; ready_i one cycle after valid_o with rdata_i=0xDEADBEEF -> valid_o 1 cycle, wstrb_o=0x0, wb_ack_o 1 cycle at N+3, wb_data_o=0xDEADBEEF.
REQ-030 Write: we=1, select=0x3, data=0x12345678, addr=0x200; ready after 5 cycles -> address_o=0x200, wdata_o=0x12345678, wstrb_o=0x3, one ack.
REQ-031 Timeout: TIMEOUT=4, ready_i never -> wb_error_o one cycle after 4 WAIT cycles, no ack; late ready_i ignored; next transfer completes normally.
REQ-032 Abort: cyc dropped in WAIT, ready_i 3 cycles later -> no ack/error, FSM IDLE, following read acked normally.
REQ-033 Reset mid-op: arst_n_i pulsed low in WAIT -> all outputs 0 immediately; wb_rst_i in REQ -> IDLE next edge, valid_o 0.
REQ-034 Back-to-back: 4 consecutive reads, stb held, addresses 0x0/0x4/0x8/0xC, ready immediate -> 4 acks, 4 valid_o pulses, correct order, 4-cycle spacing.
